// File: rtl/float_pkg.sv
// Shared float field constants, operand classes and special-value detect helpers.
package float_pkg;

  typedef enum logic [1:0] {
    CLS_FINITE,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } float_class_t;

  // Field fills are sliced down to the exponent/fraction widths in use.
  localparam int MAX_FIELD = 64;
  localparam logic [MAX_FIELD-1:0] FIELD_ONES  = '1;
  localparam logic [MAX_FIELD-1:0] FIELD_ZEROS = '0;
  localparam logic                 NAN_SIGN    = 1'b0;

  function automatic logic is_zero(input logic exp_zero, input logic frac_zero);
    return exp_zero && frac_zero;
  endfunction

  function automatic logic is_inf(input logic exp_ones, input logic frac_zero);
    return exp_ones && frac_zero;
  endfunction

  function automatic logic is_nan(input logic exp_ones, input logic frac_zero);
    return exp_ones && !frac_zero;
  endfunction

endpackage

// File: rtl/float_classify.sv
// Classifies one operand and supplies its hidden bit and effective exponent.
module float_classify
  import float_pkg::*;
#(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic [EXPONENT_SIZE-1:0] i_exp,
  input  logic [MANTISSA_SIZE-1:0] i_frac,
  output float_class_t             o_class,
  output logic                     o_hidden,
  output logic [EXPONENT_SIZE-1:0] o_eff_exp
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_frac_zero;

  assign w_exp_zero  = (i_exp == '0);
  assign w_exp_ones  = &i_exp;
  assign w_frac_zero = (i_frac == '0);

  // Subnormals carry no hidden bit and share the smallest normal exponent.
  assign o_hidden  = ~w_exp_zero;
  assign o_eff_exp = w_exp_zero ? EXPONENT_SIZE'(1) : i_exp;

  always_comb begin
    o_class = CLS_FINITE;
    if (is_nan(w_exp_ones, w_frac_zero))       o_class = CLS_NAN;
    else if (is_inf(w_exp_ones, w_frac_zero))  o_class = CLS_INF;
    else if (is_zero(w_exp_zero, w_frac_zero)) o_class = CLS_ZERO;
  end

endmodule

// File: rtl/float_multiplier.sv
// Single-cycle-latency floating-point multiplier, truncating by default.
// Define FLOAT_MULTIPLIER_RNE_EN to round to nearest, ties to even.
module float_multiplier
  import float_pkg::*;
#(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  out_valid,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact
);

  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int PW = 2 * M + 2;
  localparam int LW = $clog2(PW);
  localparam int EW = E + LW + 3;
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 ** E - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

  float_class_t    w_cls_a, w_cls_b;
  logic            w_hid_a, w_hid_b;
  logic [E-1:0]    w_eff_a, w_eff_b;
  logic            w_sign;
  logic [PW-1:0]   w_prod;
  logic [LW-1:0]   w_lead;
  logic [LW-1:0]   w_shamt;
  logic [PW-2:0]   w_norm;
  logic [M-1:0]    w_frac_trunc;
  logic            w_discard;
  logic            w_round_up;
  logic [M:0]      w_frac_sum;
  logic signed [EW-1:0] w_exp_pre;
  logic signed [EW-1:0] w_exp;
  logic [FLOAT_SIZE-1:0] w_res;
  logic            w_ovf, w_unf, w_inx;
  logic            w_any_nan, w_any_zero, w_any_inf;

  logic [FLOAT_SIZE-1:0] r_out;
  logic            r_valid, r_ovf, r_unf, r_inx;

  float_classify #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M)) u_class_a (
    .i_exp(a[FLOAT_SIZE-2 -: E]), .i_frac(a[M-1:0]),
    .o_class(w_cls_a), .o_hidden(w_hid_a), .o_eff_exp(w_eff_a)
  );

  float_classify #(.EXPONENT_SIZE(E), .MANTISSA_SIZE(M)) u_class_b (
    .i_exp(b[FLOAT_SIZE-2 -: E]), .i_frac(b[M-1:0]),
    .o_class(w_cls_b), .o_hidden(w_hid_b), .o_eff_exp(w_eff_b)
  );

  assign w_sign = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
  assign w_prod = PW'({w_hid_a, a[M-1:0]}) * PW'({w_hid_b, b[M-1:0]});

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (w_prod[i]) w_lead = LW'(i);
    end
  end

  // The leading one is shifted out of the top so only fraction and discard bits remain.
  assign w_shamt      = LW'(PW - 1) - w_lead;
  assign w_norm       = (PW - 1)'(w_prod << w_shamt);
  assign w_frac_trunc = w_norm[PW-2 -: M];
  assign w_discard    = |w_norm[M:0];
  assign w_exp_pre    = EW'(w_eff_a) + EW'(w_eff_b) - EW'(BIAS) + EW'(w_lead) - EW'(2 * M);

`ifdef FLOAT_MULTIPLIER_RNE_EN
  assign w_round_up = w_norm[M] & ((|w_norm[M-1:0]) | w_norm[M+1]);
`else
  assign w_round_up = 1'b0;
`endif

  // A carry out of the fraction means the significand rolled over to 2.0.
  assign w_frac_sum = {1'b0, w_frac_trunc} + (M + 1)'(w_round_up);
  assign w_exp      = w_exp_pre + EW'(w_frac_sum[M]);

  assign w_any_nan  = (w_cls_a == CLS_NAN)  || (w_cls_b == CLS_NAN);
  assign w_any_zero = (w_cls_a == CLS_ZERO) || (w_cls_b == CLS_ZERO);
  assign w_any_inf  = (w_cls_a == CLS_INF)  || (w_cls_b == CLS_INF);

  always_comb begin
    w_res = {w_sign, w_exp[E-1:0], w_frac_sum[M-1:0]};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = 1'b0;
    if (w_any_nan || (w_any_zero && w_any_inf)) begin
      w_res = {NAN_SIGN, FIELD_ONES[E-1:0], FIELD_ONES[M-1:0]};
    end else if (w_any_zero) begin
      w_res = {w_sign, FIELD_ZEROS[E-1:0], FIELD_ZEROS[M-1:0]};
    end else if (w_any_inf) begin
      w_res = {w_sign, FIELD_ONES[E-1:0], FIELD_ZEROS[M-1:0]};
    end else if (w_exp >= EXP_MAX) begin
      w_res = {w_sign, FIELD_ONES[E-1:0], FIELD_ZEROS[M-1:0]};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp < EXP_MIN) begin
      w_res = {w_sign, FIELD_ZEROS[E-1:0], FIELD_ZEROS[M-1:0]};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end else begin
      w_inx = w_discard;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inx   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_res;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
        r_inx <= w_inx;
      end
    end
  end

  assign out_valid = r_valid;
  assign out       = r_out;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign inexact   = r_inx;

endmodule

// File: tb/tb_float_multiplier.sv
// Self-checking bench for float_multiplier: real-arithmetic model plus directed literals.
module tb_float_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [31:0] out;
  logic        overflow, underflow, inexact;

  int nVectors = 0;
  int nFail    = 0;
  logic checkEn = 1'b0;

  logic [34:0] expHeld;
  logic        expValid;

  always #5 clk = ~clk;

  float_multiplier dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .out(out),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  // Exact value arithmetic in reals; returns {result, overflow, underflow, inexact}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, e;
    longint fx, fy, mx, my, frac;
    real    v, scaled, rem;
    logic   s, nanX, nanY, infX, infY, zeroX, zeroY, inx;
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    s = x[31] ^ y[31];
    nanX = (ex == 255) && (fx != 0);  nanY = (ey == 255) && (fy != 0);
    infX = (ex == 255) && (fx == 0);  infY = (ey == 255) && (fy == 0);
    zeroX = (ex == 0) && (fx == 0);   zeroY = (ey == 0) && (fy == 0);
    if (nanX || nanY) return {32'h7FFFFFFF, 3'b000};
    if ((zeroX && infY) || (infX && zeroY)) return {32'h7FFFFFFF, 3'b000};
    if (zeroX || zeroY) return {s, 31'h0, 3'b000};
    if (infX || infY) return {s, 8'hFF, 23'h0, 3'b000};
    mx = (ex == 0) ? fx : fx + 64'd8388608;
    my = (ey == 0) ? fy : fy + 64'd8388608;
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    v = real'(mx * my);
    e = ex + ey - 127 - 46;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    scaled = (v - 1.0) * 8388608.0;
    frac = longint'($rtoi(scaled));
    rem = scaled - real'(frac);
    inx = (rem != 0.0);
`ifdef FLOAT_MULTIPLIER_RNE_EN
    if (rem > 0.5 || (rem == 0.5 && (frac % 2) == 1)) frac++;
    if (frac == 64'd8388608) begin frac = 0; e++; end
`endif
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
    if (e < 1)    return {s, 31'h0, 3'b011};
    return {s, 8'(e), 23'(frac), 2'b00, inx};
  endfunction

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got valid/out/flags %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expHeld  <= '0;
      expValid <= 1'b0;
    end else begin
      expValid <= in_valid;
      if (in_valid) expHeld <= model(a, b);
    end
  end

  always @(negedge clk) begin
    if (checkEn)
      checkOutput("cycle compare", {out_valid, out, overflow, underflow, inexact},
                  {expValid, expHeld});
  end

  task automatic applyStimulus(input string name, input logic [31:0] x, input logic [31:0] y,
                               input logic [34:0] lit);
    checkOutput({name, " model"}, {1'b0, model(x, y)}, {1'b0, lit});
    @(posedge clk); #1;
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    checkOutput({name, " dut"}, {out_valid, out, overflow, underflow, inexact}, {1'b1, lit});
    @(negedge clk);
    checkOutput({name, " hold"}, {out_valid, out, overflow, underflow, inexact}, {1'b0, lit});
  endtask

  initial begin
    #100000;
    nFail++;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

  initial begin
    #2;
    checkOutput("reset state", {out_valid, out, overflow, underflow, inexact}, 36'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkEn = 1'b1;

    applyStimulus("1.5x2",        32'h3FC00000, 32'h40000000, {32'h40400000, 3'b000});
    applyStimulus("-2x3",         32'hC0000000, 32'h40400000, {32'hC0C00000, 3'b000});
    applyStimulus("overflow",     32'h7F3FFFFF, 32'h41400000, {32'h7F800000, 3'b101});
    applyStimulus("underflow",    32'h003FFFFF, 32'h07C00000, {32'h00000000, 3'b011});
    applyStimulus("ulp square",   32'h3F800001, 32'h3F800001, {32'h3F800002, 3'b001});
    applyStimulus("zero x inf",   32'h00000000, 32'h7F800000, {32'h7FFFFFFF, 3'b000});
    applyStimulus("one x one",    32'h3F800000, 32'h3F800000, {32'h3F800000, 3'b000});
    applyStimulus("subnormal",    32'h00400000, 32'h43000000, {32'h03800000, 3'b000});
    applyStimulus("max normal",   32'h7F000000, 32'h3F800000, {32'h7F000000, 3'b000});
    applyStimulus("ovf edge",     32'h7F000000, 32'h40000000, {32'h7F800000, 3'b101});
    applyStimulus("neg ovf",      32'hFF000000, 32'h40000000, {32'hFF800000, 3'b101});
    applyStimulus("min normal",   32'h00800000, 32'h3F800000, {32'h00800000, 3'b000});
    applyStimulus("unf edge",     32'h00800000, 32'h3F000000, {32'h00000000, 3'b011});
    applyStimulus("nan in",       32'hFFC00000, 32'h3F800000, {32'h7FFFFFFF, 3'b000});
    applyStimulus("-0 x -inf",    32'h80000000, 32'hFF800000, {32'h7FFFFFFF, 3'b000});
    applyStimulus("-0 x 1",       32'h80000000, 32'h3F800000, {32'h80000000, 3'b000});
    applyStimulus("-0 x -1",      32'h80000000, 32'hBF800000, {32'h00000000, 3'b000});
    applyStimulus("inf x -2",     32'h7F800000, 32'hC0000000, {32'hFF800000, 3'b000});
    applyStimulus("near 2 sq",    32'h3FFFFFFF, 32'h3FFFFFFF, {32'h407FFFFE, 3'b001});
`ifdef FLOAT_MULTIPLIER_RNE_EN
    applyStimulus("round tie+",   32'h3FC00001, 32'h3FC00001, {32'h40100002, 3'b001});
`else
    applyStimulus("round tie+",   32'h3FC00001, 32'h3FC00001, {32'h40100001, 3'b001});
`endif

    // Mixed back-to-back and idle cycles with in-range and arbitrary operands.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      if (i < 20) begin
        a = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end else begin
        a = $urandom;
        b = $urandom;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;

    // Reset in the cycle after a valid input wipes the fresh result.
    @(posedge clk); #1;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    #1 checkOutput("reset async", {out_valid, out, overflow, underflow, inexact}, 36'h0);
    @(negedge clk);
    checkOutput("reset held", {out_valid, out, overflow, underflow, inexact}, 36'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset idle", {out_valid, out, overflow, underflow, inexact}, 36'h0);
    applyStimulus("after reset",  32'hC0000000, 32'h40400000, {32'hC0C00000, 3'b000});

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
